// File: rtl/frame_check_sequence_engine.sv
// Ethernet CRC-32 FCS engine: folds DATA_BYTES kept bytes per beat into the LFSR and
// reports FCS, residue check, saturating frame length and keep errors one cycle after frame end.
module frame_check_sequence_engine #(
    parameter int unsigned DATA_BYTES   = 4,
    parameter int unsigned LENGTH_WIDTH = 16
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [DATA_BYTES-1:0]   data_keep,
    input  logic                    data_enable,
    input  logic                    data_last,
    input  logic                    data_abort,
    output logic [31:0]             checksum,
    output logic                    checksum_valid,
    output logic                    fcs_match,
    output logic [LENGTH_WIDTH-1:0] frame_length,
    output logic                    keep_error
);
    localparam logic [31:0] POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] RESIDUE = 32'hC704_DD7B;

    typedef enum logic {IDLE, ACTIVE} state_t;
    state_t state, state_next;

    logic [31:0]             lfsr, lfsr_base, lfsr_next, fcs_rev;
    logic [LENGTH_WIDTH-1:0] byte_count, count_next;
    logic [LENGTH_WIDTH:0]   kept_sum, count_sum;
    logic [DATA_BYTES-1:0]   keep_inc;
    logic                    error_flag, keep_bad, frame_end;

    // Non-reflected LFSR step; data bits enter LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] r;
        r = crc;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r[31] ^ b[i]) r = {r[30:0], 1'b0} ^ POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!data_abort && data_enable && !data_last) state_next = ACTIVE;
            ACTIVE:  if (data_abort || (data_enable && data_last)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign lfsr_base = (state == IDLE) ? '1 : lfsr;
    assign frame_end = data_enable & data_last & ~data_abort;

    always_comb begin
        lfsr_next = lfsr_base;
        kept_sum  = '0;
        for (int unsigned k = 0; k < DATA_BYTES; k++) begin
            if (data_keep[k]) begin
                lfsr_next = crc_byte(lfsr_next, data[8*k +: 8]);
                kept_sum  = kept_sum + (LENGTH_WIDTH+1)'(1);
            end
        end
    end

    always_comb begin
        count_sum  = {1'b0, byte_count} + kept_sum;
        count_next = count_sum[LENGTH_WIDTH] ? '1 : count_sum[LENGTH_WIDTH-1:0];
    end

    // A last-beat keep is legal only as a nonzero run of ones from bit 0 (keep & (keep+1) == 0).
    always_comb begin
        keep_inc = data_keep + DATA_BYTES'(1);
        if (data_last) keep_bad = (data_keep == '0) || ((data_keep & keep_inc) != '0);
        else           keep_bad = (data_keep != '1);
    end

    always_comb begin
        fcs_rev = '0;
        for (int unsigned i = 0; i < 32; i++) fcs_rev[i] = ~lfsr_next[31-i];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lfsr           <= '1;
            byte_count     <= '0;
            error_flag     <= 1'b0;
            checksum       <= '0;
            checksum_valid <= 1'b0;
            fcs_match      <= 1'b0;
            frame_length   <= '0;
            keep_error     <= 1'b0;
        end else begin
            checksum_valid <= 1'b0;
            if (data_abort || frame_end) begin
                lfsr       <= '1;
                byte_count <= '0;
                error_flag <= 1'b0;
            end else if (data_enable) begin
                lfsr       <= lfsr_next;
                byte_count <= count_next;
                error_flag <= error_flag | keep_bad;
            end
            if (frame_end) begin
                checksum       <= {fcs_rev[7:0], fcs_rev[15:8], fcs_rev[23:16], fcs_rev[31:24]};
                checksum_valid <= 1'b1;
                fcs_match      <= (lfsr_next == RESIDUE);
                frame_length   <= count_next;
                keep_error     <= error_flag | keep_bad;
            end
        end
    end
endmodule

// File: tb/tb_frame_check_sequence_engine.sv
// Bench for frame_check_sequence_engine: vector table, directed multi-cycle cases and
// randomized frames scored against a reflected (table-free) CRC-32 reference.
module tb_frame_check_sequence_engine;
    logic clock = 1'b0;
    logic reset_n;
    always #5 clock = ~clock;

    localparam logic [31:0] CS  = 32'h2639_F4CB;
    localparam logic [31:0] BA  = 32'h3433_3231;
    localparam logic [31:0] BB  = 32'h3837_3635;
    localparam logic [31:0] BC  = 32'h0000_0039;

    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_en, m_last, m_abort;
    logic [31:0] m_cs;
    logic        m_cv, m_match, m_kerr;
    logic [15:0] m_len;

    logic [7:0]  n_data;
    logic [0:0]  n_keep;
    logic        n_en, n_last, n_abort;
    logic [31:0] n_cs;
    logic        n_cv, n_match, n_kerr;
    logic [3:0]  n_len;

    frame_check_sequence_engine #(.DATA_BYTES(4), .LENGTH_WIDTH(16)) u_main (
        .clock(clock), .reset_n(reset_n), .data(m_data), .data_keep(m_keep),
        .data_enable(m_en), .data_last(m_last), .data_abort(m_abort),
        .checksum(m_cs), .checksum_valid(m_cv), .fcs_match(m_match),
        .frame_length(m_len), .keep_error(m_kerr)
    );

    frame_check_sequence_engine #(.DATA_BYTES(1), .LENGTH_WIDTH(4)) u_narrow (
        .clock(clock), .reset_n(reset_n), .data(n_data), .data_keep(n_keep),
        .data_enable(n_en), .data_last(n_last), .data_abort(n_abort),
        .checksum(n_cs), .checksum_valid(n_cv), .fcs_match(n_match),
        .frame_length(n_len), .keep_error(n_kerr)
    );

    typedef logic [7:0] byte_q_t[$];
    typedef struct packed {
        logic [31:0] cs;
        logic        match;
        logic [15:0] len;
        logic        kerr;
    } pulse_t;

    typedef struct {
        int unsigned      nbeats;
        logic [3:0][31:0] d;
        logic [3:0][3:0]  k;
        logic             chk_cs;
        logic [31:0]      cs;
        logic             match;
        logic [15:0]      len;
        logic             kerr;
    } vec_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    pulse_t m_obs[$];
    pulse_t m_exp[$];

    always @(negedge clock) if (m_cv === 1'b1) m_obs.push_back({m_cs, m_match, m_len, m_kerr});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reflected CRC-32 register (no final inversion) over a byte stream.
    function automatic logic [31:0] ref_crc(input byte_q_t q);
        logic [31:0] c;
        c = '1;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [31:0] ref_fcs(input logic [31:0] c);
        logic [31:0] f;
        f = ~c;
        return {f[7:0], f[15:8], f[23:16], f[31:24]};
    endfunction

    task automatic m_beat(input logic [31:0] d, input logic [3:0] k, input logic en,
                          input logic last, input logic ab);
        @(negedge clock);
        m_data = d; m_keep = k; m_en = en; m_last = last; m_abort = ab;
    endtask

    task automatic m_idle(input int n);
        repeat (n) m_beat(32'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic n_beat(input logic [7:0] d, input logic en, input logic last);
        @(negedge clock);
        n_data = d; n_keep = en; n_en = en; n_last = last; n_abort = 1'b0;
    endtask

    task automatic m_frame123();
        m_beat(BA, 4'hF, 1'b1, 1'b0, 1'b0);
        m_beat(BB, 4'hF, 1'b1, 1'b0, 1'b0);
        m_beat(BC, 4'h1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic expect_same(input string tag, input int n, input logic [31:0] cs, input logic [15:0] len);
        pulse_t p;
        #1;
        check({tag, "_pulses"}, 64'(m_obs.size()), 64'(n));
        while (m_obs.size() != 0) begin
            p = m_obs.pop_front();
            check({tag, "_cs"}, 64'(p.cs), 64'(cs));
            check({tag, "_len"}, 64'(p.len), 64'(len));
            check({tag, "_kerr"}, 64'(p.kerr), 64'(0));
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_m_cs"}, 64'(m_cs), 64'(0));
        check({tag, "_m_cv"}, 64'(m_cv), 64'(0));
        check({tag, "_m_match"}, 64'(m_match), 64'(0));
        check({tag, "_m_len"}, 64'(m_len), 64'(0));
        check({tag, "_m_kerr"}, 64'(m_kerr), 64'(0));
        check({tag, "_n_cs"}, 64'(n_cs), 64'(0));
        check({tag, "_n_len"}, 64'(n_len), 64'(0));
        check({tag, "_n_cv"}, 64'(n_cv), 64'(0));
    endtask

    task automatic rand_frame();
        byte_q_t bytes, kept;
        int nb, rem, err_beat, abort_beat;
        logic do_err, do_abort, is_last, kerr;
        logic [3:0] k;
        logic [31:0] d, c;
        for (int i = 0; i < int'($urandom_range(30, 1)); i++) bytes.push_back(8'($urandom));
        if ($urandom_range(2, 0) == 0) begin
            c = ~ref_crc(bytes);
            bytes.push_back(c[7:0]);   bytes.push_back(c[15:8]);
            bytes.push_back(c[23:16]); bytes.push_back(c[31:24]);
        end
        nb         = (bytes.size() + 3) / 4;
        do_err     = ($urandom_range(5, 0) == 0);
        err_beat   = int'($urandom_range(nb - 1, 0));
        do_abort   = ($urandom_range(7, 0) == 0);
        abort_beat = int'($urandom_range(nb - 1, 0));
        kerr       = 1'b0;
        for (int b = 0; b < nb; b++) begin
            is_last = (b == nb - 1);
            rem     = bytes.size() - 4 * b;
            k       = (!is_last || rem >= 4) ? 4'hF : 4'((1 << rem) - 1);
            if (do_err && b == err_beat) begin
                if (is_last) do k = 4'($urandom); while (k inside {4'h1, 4'h3, 4'h7, 4'hF});
                else         do k = 4'($urandom); while (k == 4'hF);
            end
            for (int j = 0; j < 4; j++)
                d[8*j +: 8] = (4 * b + j < bytes.size()) ? bytes[4 * b + j] : 8'($urandom);
            if ($urandom_range(9, 0) == 0)
                m_beat(32'($urandom), 4'($urandom), 1'b0, 1'($urandom_range(1, 0)), 1'b0);
            if (do_abort && b == abort_beat) begin
                m_beat(d, k, 1'($urandom_range(1, 0)), is_last, 1'b1);
                return;
            end
            m_beat(d, k, 1'b1, is_last, 1'b0);
            for (int j = 0; j < 4; j++) if (k[j]) kept.push_back(d[8*j +: 8]);
            if (is_last ? !(k inside {4'h1, 4'h3, 4'h7, 4'hF}) : (k != 4'hF)) kerr = 1'b1;
        end
        c = ref_crc(kept);
        m_exp.push_back({ref_fcs(c), (c == 32'hDEBB_20E3), 16'(kept.size()), kerr});
    endtask

    task automatic rand_compare();
        pulse_t p, e;
        #1;
        check("rand_pulses", 64'(m_obs.size()), 64'(m_exp.size()));
        while (m_obs.size() != 0 && m_exp.size() != 0) begin
            p = m_obs.pop_front();
            e = m_exp.pop_front();
            check("rand_cs", 64'(p.cs), 64'(e.cs));
            check("rand_match", 64'(p.match), 64'(e.match));
            check("rand_len", 64'(p.len), 64'(e.len));
            check("rand_kerr", 64'(p.kerr), 64'(e.kerr));
        end
        m_obs.delete();
        m_exp.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t   vecs[8];
        pulse_t p;
        byte_q_t q;
        logic [7:0] b8;

        vecs[0] = '{3, {32'h0, 32'hAAAA_AA39, BB, BA}, {4'h0, 4'h1, 4'hF, 4'hF}, 1'b1, CS, 1'b0, 16'd9, 1'b0};
        vecs[1] = '{4, {32'hAAAA_AACB, 32'hF439_2639, BB, BA}, {4'h1, 4'hF, 4'hF, 4'hF}, 1'b1, 32'h1CDF_4421, 1'b1, 16'd13, 1'b0};
        vecs[2] = '{4, {32'hAAAA_AACB, 32'hF439_2639, BB, 32'h3433_3230}, {4'h1, 4'hF, 4'hF, 4'hF}, 1'b0, 32'h0, 1'b0, 16'd13, 1'b0};
        vecs[3] = '{3, {32'h0, 32'h55AA_5539, BB, BA}, {4'h0, 4'h5, 4'hF, 4'hF}, 1'b0, 32'h0, 1'b0, 16'd10, 1'b1};
        vecs[4] = '{2, {32'h0, 32'h0, BB, BA}, {4'h0, 4'h0, 4'hF, 4'h7}, 1'b0, 32'h0, 1'b0, 16'd7, 1'b1};
        vecs[5] = '{2, {32'h0, 32'h0, BB, BA}, {4'h0, 4'h0, 4'h0, 4'hF}, 1'b0, 32'h0, 1'b0, 16'd4, 1'b1};
        vecs[6] = vecs[0];
        vecs[7] = '{1, {32'h0, 32'h0, 32'h0, BA}, {4'h0, 4'h0, 4'h0, 4'h3}, 1'b0, 32'h0, 1'b0, 16'd2, 1'b0};

        reset_n = 1'b0;
        m_data = '0; m_keep = '0; m_en = 1'b0; m_last = 1'b0; m_abort = 1'b0;
        n_data = '0; n_keep = '0; n_en = 1'b0; n_last = 1'b0; n_abort = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check_outputs_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            for (int b = 0; b < int'(vecs[i].nbeats); b++)
                m_beat(vecs[i].d[b], vecs[i].k[b], 1'b1, (b == int'(vecs[i].nbeats) - 1), 1'b0);
            m_idle(2);
            #1;
            check($sformatf("vec%0d_pulses", i), 64'(m_obs.size()), 64'(1));
            if (m_obs.size() != 0) begin
                p = m_obs.pop_front();
                if (vecs[i].chk_cs) check($sformatf("vec%0d_cs", i), 64'(p.cs), 64'(vecs[i].cs));
                check($sformatf("vec%0d_match", i), 64'(p.match), 64'(vecs[i].match));
                check($sformatf("vec%0d_len", i), 64'(p.len), 64'(vecs[i].len));
                check($sformatf("vec%0d_kerr", i), 64'(p.kerr), 64'(vecs[i].kerr));
            end
            m_obs.delete();
        end

        for (int i = 0; i < 9; i++) n_beat(8'(49 + i), 1'b1, (i == 8));
        n_beat(8'h0, 1'b0, 1'b0);
        #1;
        check("n1_cv", 64'(n_cv), 64'(1));
        check("n1_cs", 64'(n_cs), 64'(CS));
        check("n1_len", 64'(n_len), 64'(9));
        check("n1_kerr", 64'(n_kerr), 64'(0));
        n_beat(8'h0, 1'b0, 1'b0);
        #1;
        check("n1_cv_drop", 64'(n_cv), 64'(0));
        check("n1_cs_hold", 64'(n_cs), 64'(CS));

        for (int i = 0; i < 20; i++) begin
            b8 = 8'($urandom);
            q.push_back(b8);
            n_beat(b8, 1'b1, (i == 19));
        end
        n_beat(8'h0, 1'b0, 1'b0);
        #1;
        check("nsat_cv", 64'(n_cv), 64'(1));
        check("nsat_len", 64'(n_len), 64'(15));
        check("nsat_cs", 64'(n_cs), 64'(ref_fcs(ref_crc(q))));
        check("nsat_kerr", 64'(n_kerr), 64'(0));

        m_frame123();
        m_frame123();
        m_idle(2);
        expect_same("b2b", 2, CS, 16'd9);

        m_beat(BA, 4'hF, 1'b1, 1'b0, 1'b0);
        m_beat(BB, 4'hF, 1'b1, 1'b0, 1'b1);
        m_frame123();
        m_idle(2);
        expect_same("abort_mid", 1, CS, 16'd9);

        m_beat(BA, 4'hF, 1'b1, 1'b0, 1'b0);
        m_beat(BB, 4'hF, 1'b1, 1'b0, 1'b0);
        m_beat(BC, 4'h1, 1'b1, 1'b1, 1'b1);
        m_idle(2);
        expect_same("abort_last", 0, CS, 16'd9);
        m_frame123();
        m_idle(2);
        expect_same("after_abort", 1, CS, 16'd9);

        m_beat(BA, 4'hF, 1'b1, 1'b0, 1'b0);
        m_beat(32'hFFFF_FFFF, 4'hF, 1'b0, 1'b1, 1'b0);
        m_beat(BB, 4'hF, 1'b1, 1'b0, 1'b0);
        m_beat(BC, 4'h1, 1'b1, 1'b1, 1'b0);
        m_idle(2);
        expect_same("last_no_en", 1, CS, 16'd9);
        m_idle(3);
        #1;
        check("hold_cs", 64'(m_cs), 64'(CS));
        check("hold_len", 64'(m_len), 64'(9));
        check("hold_cv", 64'(m_cv), 64'(0));

        m_beat(BA, 4'hF, 1'b1, 1'b0, 1'b0);
        m_idle(1);
        #2 reset_n = 1'b0;
        #1;
        check_outputs_zero("rst_mid");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        m_idle(2);
        expect_same("rst_mid", 0, CS, 16'd9);
        m_frame123();
        m_idle(2);
        expect_same("after_rst", 1, CS, 16'd9);

        for (int batch = 0; batch < 40; batch++) begin
            for (int f = 0; f < int'($urandom_range(5, 1)); f++) begin
                rand_frame();
                m_idle(int'($urandom_range(2, 0)));
            end
            m_idle(2);
            rand_compare();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
